// File: rtl/mcmc_top_control_unit_pkg.sv
// Shared definitions for the MCMC top-level sequencer.
//   - ctrl_state_t : controller state codes as seen on out_top_module_state
//   - SEARCH_*     : state codes reported by the probabilistic search FSM
//   - var_type_t   : two-bit variable type encodings of the type table
//   - PROB_W/ONE   : unsigned Q0.16 acceptance-probability format
//   - metropolis_accept : accept/reject rule for one proposal
package mcmc_top_control_unit_pkg;

  localparam int PROB_W = 16;
  localparam logic [PROB_W-1:0] PROB_ONE = 16'hFFFF;

  typedef enum logic [7:0] {
    ST_IDLE             = 8'd0,
    ST_PROBABILISTIC    = 8'd1,
    ST_CHOOSE_VARIABLE  = 8'd2,
    ST_WAIT_SEARCH      = 8'd3,
    ST_WAIT_PROBABILITY = 8'd4,
    ST_DECIDE           = 8'd5,
    ST_COMMIT           = 8'd6,
    ST_FINISHED         = 8'd7,
    ST_ERROR            = 8'd8
  } ctrl_state_t;

  localparam logic [7:0] SEARCH_IDLE = 8'd2;
  localparam logic [7:0] SEARCH_DONE = 8'd11;

  typedef enum logic [1:0] {
    VT_BOOLEAN  = 2'b00,
    VT_CONT_INT = 2'b01,
    VT_DISC_INT = 2'b10,
    VT_RESERVED = 2'b11
  } var_type_t;

  // 16'hFFFF stands for exactly 1.0, which a strict compare against a
  // 16-bit random word could otherwise miss when the word is also 16'hFFFF.
  function automatic logic metropolis_accept(input logic [PROB_W-1:0] prob,
                                             input logic [PROB_W-1:0] rnd);
    return (prob == PROB_ONE) || (rnd < prob);
  endfunction

endpackage

// File: rtl/mcmc_top_control_unit_variable_selector.sv
// Variable selection for one MCMC iteration.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   advance        : step the round-robin pointer (one pulse per iteration)
//   candidate      : random index proposal
//   variable_types : packed type table, entry i at bits [2i+1:2i]
//   index          : selected variable (combinational)
//   var_type       : type of the selected variable (combinational)
module mcmc_top_control_unit_variable_selector
  import mcmc_top_control_unit_pkg::*;
#(
  parameter int NUM_VARIABLES   = 8,
  parameter int VAR_INDEX_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         advance,
  input  logic [VAR_INDEX_WIDTH-1:0]   candidate,
  input  logic [2*NUM_VARIABLES-1:0]   variable_types,
  output logic [VAR_INDEX_WIDTH-1:0]   index,
  output logic [1:0]                   var_type
);

  localparam logic [VAR_INDEX_WIDTH:0]   NUM_VARS = (VAR_INDEX_WIDTH+1)'(NUM_VARIABLES);
  localparam logic [VAR_INDEX_WIDTH-1:0] RR_LAST  = VAR_INDEX_WIDTH'(NUM_VARIABLES - 1);

  logic [VAR_INDEX_WIDTH-1:0] rr_ptr;

  // Pointer moves every iteration, whether or not it was used, so that
  // out-of-range random proposals still sweep the whole variable set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + 1'b1;
    end
  end

  always_comb begin
    index = candidate;
    if ({1'b0, candidate} >= NUM_VARS) begin
      index = rr_ptr;
    end
  end

  // Explicit decode keeps the lookup inside the table when 2**W exceeds
  // NUM_VARIABLES.
  always_comb begin
    var_type = VT_BOOLEAN;
    for (int i = 0; i < NUM_VARIABLES; i++) begin
      if (index == VAR_INDEX_WIDTH'(i)) begin
        var_type = variable_types[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/mcmc_top_control_unit.sv
// Top-level MCMC sequencer: initiator side of the probabilistic-search
// handshake. Each iteration chooses a variable, launches the search FSM
// with a single PROBABILISTIC cycle, waits for DONE and then for the
// acceptance probability, makes the Metropolis decision and pulses commit.
// Ports:
//   in_clk, in_reset_n            : clock, asynchronous active-low reset
//   in_start                      : run request (IDLE/FINISHED/ERROR only)
//   in_variable_types             : packed two-bit type table
//   in_random                     : free-running random word
//   in_probabilistic_search_state : search FSM state code
//   in_probability(_valid)        : Q0.16 acceptance ratio and qualifier
//   out_top_module_state          : controller state code
//   out_chosen_variable_index     : latched variable index
//   out_choosen_variable_type     : latched variable type
//   out_accept                    : decision of the last iteration
//   out_commit_enable             : one-cycle commit pulse
//   out_iteration_count           : completed iterations this run
//   out_done                      : run finished
//   out_timeout_error             : sticky timeout flag
module mcmc_top_control_unit
  import mcmc_top_control_unit_pkg::*;
#(
  parameter int NUM_VARIABLES   = 8,
  parameter int VAR_INDEX_WIDTH = 3,
  parameter int NUM_ITERATIONS  = 16,
  parameter int TIMEOUT_CYCLES  = 32
) (
  input  logic                        in_clk,
  input  logic                        in_reset_n,
  input  logic                        in_start,
  input  logic [2*NUM_VARIABLES-1:0]  in_variable_types,
  input  logic [15:0]                 in_random,
  input  logic [7:0]                  in_probabilistic_search_state,
  input  logic [15:0]                 in_probability,
  input  logic                        in_probability_valid,
  output logic [7:0]                  out_top_module_state,
  output logic [VAR_INDEX_WIDTH-1:0]  out_chosen_variable_index,
  output logic [1:0]                  out_choosen_variable_type,
  output logic                        out_accept,
  output logic                        out_commit_enable,
  output logic [15:0]                 out_iteration_count,
  output logic                        out_done,
  output logic                        out_timeout_error
);

  localparam logic [15:0] ITER_LAST = 16'(NUM_ITERATIONS - 1);
  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  ctrl_state_t                state_q, state_d;
  logic [VAR_INDEX_WIDTH-1:0] index_q;
  logic [1:0]                 type_q;
  logic [PROB_W-1:0]          prob_q;
  logic                       accept_q;
  logic [15:0]                count_q;
  logic [7:0]                 tmo_q;
  logic                       err_q;

  logic [VAR_INDEX_WIDTH-1:0] sel_index;
  logic [1:0]                 sel_type;

  logic start_run, latch_sel, latch_prob, decide, iter_end;
  logic tmo_clr, tmo_inc, err_set, accept_now, last_iter;

  mcmc_top_control_unit_variable_selector #(
    .NUM_VARIABLES   (NUM_VARIABLES),
    .VAR_INDEX_WIDTH (VAR_INDEX_WIDTH)
  ) u_selector (
    .clk            (in_clk),
    .rst_n          (in_reset_n),
    .advance        (latch_sel),
    .candidate      (in_random[VAR_INDEX_WIDTH-1:0]),
    .variable_types (in_variable_types),
    .index          (sel_index),
    .var_type       (sel_type)
  );

  assign accept_now = metropolis_accept(prob_q, in_random);
  assign last_iter  = (count_q == ITER_LAST);

  always_comb begin
    state_d    = state_q;
    start_run  = 1'b0;
    latch_sel  = 1'b0;
    latch_prob = 1'b0;
    decide     = 1'b0;
    iter_end   = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_FINISHED, ST_ERROR: begin
        if (in_start) begin
          start_run = 1'b1;
          state_d   = ST_CHOOSE_VARIABLE;
        end
      end
      ST_CHOOSE_VARIABLE: begin
        latch_sel = 1'b1;
        // Reserved-type variables are counted but never searched.
        if (sel_type == VT_RESERVED) begin
          iter_end = 1'b1;
        end else begin
          state_d = ST_PROBABILISTIC;
        end
      end
      ST_PROBABILISTIC: begin
        // Held for exactly one period so the negedge-updated search FSM
        // observes the launch once and cannot relaunch after DONE.
        state_d = ST_WAIT_SEARCH;
        tmo_clr = 1'b1;
      end
      ST_WAIT_SEARCH: begin
        // A simultaneous probability_valid is deliberately not consumed here.
        if (in_probabilistic_search_state == SEARCH_DONE) begin
          state_d = ST_WAIT_PROBABILITY;
          tmo_clr = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
          err_set = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_WAIT_PROBABILITY: begin
        if (in_probability_valid) begin
          latch_prob = 1'b1;
          state_d    = ST_DECIDE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
          err_set = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_DECIDE: begin
        decide = 1'b1;
        if (accept_now) begin
          state_d = ST_COMMIT;
        end else begin
          iter_end = 1'b1;
        end
      end
      ST_COMMIT: begin
        iter_end = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (iter_end) begin
      state_d = last_iter ? ST_FINISHED : ST_CHOOSE_VARIABLE;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      type_q   <= '0;
      prob_q   <= '0;
      accept_q <= 1'b0;
      count_q  <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (latch_sel) begin
        index_q <= sel_index;
        type_q  <= sel_type;
      end

      if (latch_prob) begin
        prob_q <= in_probability;
      end

      if (latch_sel && (sel_type == VT_RESERVED)) begin
        accept_q <= 1'b0;
      end else if (decide) begin
        accept_q <= accept_now;
      end

      if (start_run) begin
        count_q <= '0;
      end else if (iter_end) begin
        count_q <= count_q + 16'd1;
      end

      if (tmo_clr) begin
        tmo_q <= '0;
      end else if (tmo_inc) begin
        tmo_q <= tmo_q + 8'd1;
      end

      if (start_run) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_top_module_state      = state_q;
  assign out_chosen_variable_index = index_q;
  assign out_choosen_variable_type = type_q;
  assign out_accept                = accept_q;
  assign out_commit_enable         = (state_q == ST_COMMIT);
  assign out_iteration_count       = count_q;
  assign out_done                  = (state_q == ST_FINISHED);
  assign out_timeout_error         = err_q;

endmodule

// File: tb/tb_mcmc_top_control_unit.sv
// Directed bench for mcmc_top_control_unit (5 variables, 2 iterations per
// run, 32-cycle timeout). Inputs are driven and outputs sampled 1 ns after
// the rising edge; commit pulses and launch cycles are tallied on negedge.
module tb_mcmc_top_control_unit;
  import mcmc_top_control_unit_pkg::*;

  localparam int NV  = 5;
  localparam int IW  = 3;
  localparam int NIT = 2;
  localparam int TMO = 32;

  logic            in_clk = 1'b0;
  logic            in_reset_n;
  logic            in_start;
  logic [2*NV-1:0] in_variable_types;
  logic [15:0]     in_random;
  logic [7:0]      in_probabilistic_search_state;
  logic [15:0]     in_probability;
  logic            in_probability_valid;
  logic [7:0]      out_top_module_state;
  logic [IW-1:0]   out_chosen_variable_index;
  logic [1:0]      out_choosen_variable_type;
  logic            out_accept;
  logic            out_commit_enable;
  logic [15:0]     out_iteration_count;
  logic            out_done;
  logic            out_timeout_error;

  int n_checks  = 0;
  int n_errors  = 0;
  int commit_cnt = 0;
  int launch_cnt = 0;

  mcmc_top_control_unit #(
    .NUM_VARIABLES   (NV),
    .VAR_INDEX_WIDTH (IW),
    .NUM_ITERATIONS  (NIT),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .in_clk                        (in_clk),
    .in_reset_n                    (in_reset_n),
    .in_start                      (in_start),
    .in_variable_types             (in_variable_types),
    .in_random                     (in_random),
    .in_probabilistic_search_state (in_probabilistic_search_state),
    .in_probability                (in_probability),
    .in_probability_valid          (in_probability_valid),
    .out_top_module_state          (out_top_module_state),
    .out_chosen_variable_index     (out_chosen_variable_index),
    .out_choosen_variable_type     (out_choosen_variable_type),
    .out_accept                    (out_accept),
    .out_commit_enable             (out_commit_enable),
    .out_iteration_count           (out_iteration_count),
    .out_done                      (out_done),
    .out_timeout_error             (out_timeout_error)
  );

  always #5 in_clk = ~in_clk;

  always @(negedge in_clk) begin
    if (out_commit_enable) commit_cnt <= commit_cnt + 1;
    if (out_top_module_state == 8'(ST_PROBABILISTIC)) launch_cnt <= launch_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wait_state(input ctrl_state_t code, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (out_top_module_state == 8'(code)) break;
      tick();
    end
    check_val(tag, 32'(out_top_module_state), 32'(code));
  endtask

  task automatic pulse_start();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  // From PROBABILISTIC: let the search report DONE after done_delay cycles.
  task automatic reach_wait_prob(input int done_delay, input string tag);
    wait_state(ST_WAIT_SEARCH, 3, {tag, "_ws"});
    repeat (done_delay) tick();
    in_probabilistic_search_state = SEARCH_DONE;
    wait_state(ST_WAIT_PROBABILITY, 2, {tag, "_wp"});
    in_probabilistic_search_state = SEARCH_IDLE;
  endtask

  // One full iteration starting in CHOOSE_VARIABLE; rnd is the random word
  // presented during DECIDE (and therefore the next candidate index).
  task automatic run_iter(input logic [15:0] prob, input logic [15:0] rnd,
                          input logic exp_acc, input logic exp_last,
                          input logic [IW-1:0] exp_idx, input string tag);
    tick();
    check_val({tag, "_launch"}, 32'(out_top_module_state), 32'(ST_PROBABILISTIC));
    check_val({tag, "_idx"}, 32'(out_chosen_variable_index), 32'(exp_idx));
    reach_wait_prob(3, tag);
    in_probability       = prob;
    in_probability_valid = 1'b1;
    in_random            = rnd;
    tick();
    in_probability_valid = 1'b0;
    tick();
    check_val({tag, "_accept"}, 32'(out_accept), 32'(exp_acc));
    if (exp_acc) begin
      check_val({tag, "_commit"}, 32'(out_commit_enable), 32'd1);
      tick();
    end
    check_val({tag, "_end"}, 32'(out_top_module_state),
              exp_last ? 32'(ST_FINISHED) : 32'(ST_CHOOSE_VARIABLE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    in_reset_n = 1'b0;
    in_start = 1'b0;
    in_variable_types = '0;
    in_random = 16'h0007;
    in_probabilistic_search_state = SEARCH_IDLE;
    in_probability = '0;
    in_probability_valid = 1'b0;
    #1;
    check_val("rst_state", 32'(out_top_module_state), 32'(ST_IDLE));
    check_val("rst_outs", {out_chosen_variable_index, out_choosen_variable_type, out_accept,
              out_commit_enable, out_done, out_timeout_error}, 32'd0);
    check_val("rst_count", 32'(out_iteration_count), 32'd0);
    tick();
    tick();
    in_reset_n = 1'b1;
    tick();

    // Run 1: out-of-range candidates (7 >= 5) fall back to round robin.
    pulse_start();
    check_val("r1_choose", 32'(out_top_module_state), 32'(ST_CHOOSE_VARIABLE));
    run_iter(16'hFFFF, 16'h0007, 1'b1, 1'b0, 3'd0, "r1i1");
    check_val("r1_cnt1", 32'(out_iteration_count), 32'd1);
    run_iter(16'hFFFF, 16'h0007, 1'b1, 1'b1, 3'd1, "r1i2");
    check_val("r1_done", 32'(out_done), 32'd1);
    check_val("r1_cnt2", 32'(out_iteration_count), 32'd2);
    check_val("r1_commits", 32'(commit_cnt), 32'd2);
    check_val("r1_launches", 32'(launch_cnt), 32'd2);

    // Run 2: zero probability rejects; 0x7FFF < 0x8000 accepts.
    pulse_start();
    run_iter(16'h0000, 16'h0000, 1'b0, 1'b0, 3'd2, "r2i1");
    run_iter(16'h8000, 16'h7FFF, 1'b1, 1'b1, 3'd0, "r2i2");
    check_val("r2_commits", 32'(commit_cnt), 32'd3);

    // Run 3: equal word rejects; probability 1.0 accepts even for 0xFFFF.
    // First candidate is 7 again -> round robin 4, then wraps.
    pulse_start();
    run_iter(16'h8000, 16'h8000, 1'b0, 1'b0, 3'd4, "r3i1");
    run_iter(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 3'd0, "r3i2");
    check_val("r3_commits", 32'(commit_cnt), 32'd4);
    check_val("r3_launches", 32'(launch_cnt), 32'd6);

    // Run 4: reserved type at index 3 skips the search entirely.
    in_variable_types = 10'b00_11_00_00_00;
    in_random = 16'h0003;
    pulse_start();
    tick();
    check_val("r4_state1", 32'(out_top_module_state), 32'(ST_CHOOSE_VARIABLE));
    check_val("r4_cnt1", 32'(out_iteration_count), 32'd1);
    check_val("r4_type", 32'(out_choosen_variable_type), 32'd3);
    check_val("r4_accept", 32'(out_accept), 32'd0);
    tick();
    check_val("r4_state2", 32'(out_top_module_state), 32'(ST_FINISHED));
    check_val("r4_cnt2", 32'(out_iteration_count), 32'd2);
    check_val("r4_launches", 32'(launch_cnt), 32'd6);
    check_val("r4_commits", 32'(commit_cnt), 32'd4);

    // Run 5: search never finishes -> ERROR after exactly 32 cycles;
    // a start pulse in the middle must be ignored.
    in_random = 16'h0001;
    pulse_start();
    tick();
    check_val("r5_idx", 32'(out_chosen_variable_index), 32'd1);
    tick();
    check_val("r5_ws", 32'(out_top_module_state), 32'(ST_WAIT_SEARCH));
    for (int i = 0; i < TMO - 1; i++) begin
      in_start = (i == 10);
      tick();
    end
    in_start = 1'b0;
    check_val("r5_still_ws", 32'(out_top_module_state), 32'(ST_WAIT_SEARCH));
    check_val("r5_no_err_yet", 32'(out_timeout_error), 32'd0);
    tick();
    check_val("r5_error", 32'(out_top_module_state), 32'(ST_ERROR));
    check_val("r5_err_flag", 32'(out_timeout_error), 32'd1);
    tick();
    check_val("r5_err_sticky", 32'(out_timeout_error), 32'd1);

    // Run 6: restart from ERROR, then reset asynchronously in WAIT_PROBABILITY.
    pulse_start();
    check_val("r6_err_clr", 32'(out_timeout_error), 32'd0);
    run_iter(16'hFFFF, 16'hFFFC, 1'b1, 1'b0, 3'd1, "r6i1");
    tick();
    check_val("r6_idx", 32'(out_chosen_variable_index), 32'd4);
    reach_wait_prob(1, "r6i2");
    tick();
    check_val("r6_hold_wp", 32'(out_top_module_state), 32'(ST_WAIT_PROBABILITY));
    in_reset_n = 1'b0;
    #1;
    check_val("r6_rst_state", 32'(out_top_module_state), 32'(ST_IDLE));
    check_val("r6_rst_outs", {out_chosen_variable_index, out_choosen_variable_type, out_accept,
              out_commit_enable, out_done, out_timeout_error}, 32'd0);
    check_val("r6_rst_count", 32'(out_iteration_count), 32'd0);
    tick();
    check_val("r6_commits", 32'(commit_cnt), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
